popcount_stream_neuron: RTL and testbench
=========================================

POPCOUNT_STREAM_NEURON -- requirements
Module: popcount_stream_neuron

Interface
REQ-001 SHALL have parameter WIDTH, default 10: bits per input beat.
REQ-002 SHALL have parameter FRAMES, default 4: beats per frame (>=1).
REQ-003 SHALL have parameter TRUNC, default 2: low bits ignored in approximate mode (0..WIDTH-1).
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port clear  in  1  synchronous discard of the partial frame.
REQ-007 SHALL have port in_valid  in  1  beat valid.
REQ-008 SHALL have port in_ready  out  1  beat accepted when in_valid && in_ready.
REQ-009 SHALL have port in_pos  in  WIDTH  +1 weight mask.
REQ-010 SHALL have port in_neg  in  WIDTH  -1 weight mask.
REQ-011 SHALL have port approx_en  in  1  approximate mode, sampled on a frame's first beat.
REQ-012 SHALL have port thr_hi  in  AW signed  activation upper threshold, sampled on first beat.
REQ-013 SHALL have port thr_lo  in  AW signed  activation lower threshold, sampled on first beat.
REQ-014 SHALL have port out_valid  out  1  result valid.
REQ-015 SHALL have port out_ready  in  1  result consumed when out_valid && out_ready.
REQ-016 SHALL have port out_sum  out  AW signed  frame sum.
REQ-017 SHALL have port out_act  out  2  ternary activation: 01=+1, 11=-1, 00=0.
REQ-018 SHALL use CW=$clog2(WIDTH+1) and AW=$clog2(FRAMES*WIDTH+1)+1.

Function
REQ-019 SHALL compute per beat d = popcount(in_pos & ~in_neg) - popcount(in_neg & ~in_pos); bits set in both masks count 0.
REQ-020 SHALL, when the frame's sampled approx_en=1, ignore bits [TRUNC-1:0] of both masks for every beat of that frame.
REQ-021 SHALL have states IDLE (no beat held) and ACCUM (1..FRAMES-1 beats held); beat counter bc 0..FRAMES-1.
REQ-022 SHALL on accept in IDLE: acc<=d, latch approx_en/thr_hi/thr_lo, bc<=1, go ACCUM (or finish if FRAMES=1).
REQ-023 SHALL on accept in ACCUM: acc<=acc+d, bc<=bc+1.
REQ-024 SHALL on accepting beat FRAMES-1: load out_sum=acc+d, out_act, set out_valid next cycle, clear acc, bc<=0, go IDLE.
REQ-025 SHALL set out_act=01 if sum>=thr_hi, else 11 if sum<=thr_lo, else 00; thr_hi wins if both hold.
REQ-026 SHALL drive in_ready = !out_valid || out_ready (completion may overlap consumption in the same cycle).
REQ-027 SHALL hold out_sum/out_act/out_valid stable while out_valid && !out_ready.
REQ-028 SHALL, on clear=1: acc<=0, bc<=0, go IDLE, discard any same-cycle beat; pending out_valid result unaffected.
REQ-029 SHALL never overflow: AW is sized for ±FRAMES*WIDTH.
REQ-030 SHALL have one-beat latency: out_valid rises the cycle after the last beat is accepted.

Reset
REQ-031 SHALL on rst_n=0, immediately: state IDLE, bc=0, acc=0, out_valid=0, out_sum=0, out_act=00, latched thresholds/approx=0.
REQ-032 SHALL, on reset mid-frame, lose the partial frame; first post-reset accept starts a new frame.

Structure
REQ-033 SHALL keep the state enum and activation encodings (ACT_POS, ACT_NEG, ACT_ZERO) in the shared package popcount_pkg.
REQ-034 SHALL instantiate combinational sub-module popcount_core (parameter WIDTH, input WIDTH, output CW) twice per beat.

Verification (WIDTH=10, FRAMES=4, TRUNC=2)
REQ-035 SHALL test exact frame: pos=3FF, neg=000 x4, thr_hi=30, thr_lo=-30 -> out_sum=40, out_act=01, out_valid one cycle after beat 4.
REQ-036 SHALL test approx frame: approx_en=1 on beat 1, pos=3FF, neg=003 x4 -> out_sum=32 (bits 1:0 ignored); approx_en toggled mid-frame has no effect.
REQ-037 SHALL test overlap/conflict: pos=neg=3FF -> d=0; frame pos=000, neg=3FF x4, thr_lo=-40 -> out_sum=-40, out_act=11.
REQ-038 SHALL test backpressure: out_ready=0 after frame 1 -> in_ready=0, outputs held; out_ready=1 with beat 1 of frame 2 same cycle -> both accepted.
REQ-039 SHALL test clear after 2 beats, concurrent with a valid beat -> beat dropped, next 4 beats yield a full fresh frame sum.
REQ-040 SHALL test rst_n low mid-frame (bc=3) -> all outputs 0 asynchronously, next frame sums only post-reset beats.

Source files
------------

// File: rtl/popcount_pkg.sv
// Shared types and encodings for the popcount stream neuron.
//   state_e  : frame accumulation state (IDLE = no beat held, ACCUM = partial frame held)
//   ACT_*    : ternary activation encodings driven on out_act
package popcount_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  localparam logic [1:0] ACT_ZERO = 2'b00;
  localparam logic [1:0] ACT_POS  = 2'b01;
  localparam logic [1:0] ACT_NEG  = 2'b11;

endpackage

// File: rtl/popcount_core.sv
// Combinational population count.
//   bits_i  : WIDTH-bit input vector
//   count_o : number of set bits, $clog2(WIDTH+1) bits wide
module popcount_core #(
  parameter int unsigned WIDTH = 10
) (
  input  logic [WIDTH-1:0]             bits_i,
  output logic [$clog2(WIDTH+1)-1:0]   count_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  // Ripple sum of bits; synthesis rebalances into an adder tree.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      count_o = count_o + CW'(bits_i[i]);
    end
  end

endmodule

// File: rtl/popcount_stream_neuron.sv
// Ternary-weight popcount neuron over a stream of beats.
// Each accepted beat contributes popcount(+1 only) - popcount(-1 only); FRAMES
// beats form a frame whose sum is thresholded into a ternary activation.
//   clk, rst_n          : clock, async active-low reset
//   clear               : synchronous discard of the partial frame
//   in_valid/in_ready   : beat handshake; in_pos/in_neg are the +1/-1 masks
//   approx_en           : drop the TRUNC low bits for the whole frame (first beat)
//   thr_hi/thr_lo       : activation thresholds (sampled on first beat)
//   out_valid/out_ready : result handshake; out_sum frame sum, out_act activation
module popcount_stream_neuron
  import popcount_pkg::*;
#(
  parameter  int unsigned WIDTH  = 10,
  parameter  int unsigned FRAMES = 4,
  parameter  int unsigned TRUNC  = 2,
  localparam int unsigned CW     = $clog2(WIDTH + 1),
  localparam int unsigned AW     = $clog2(FRAMES * WIDTH + 1) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_pos,
  input  logic [WIDTH-1:0]     in_neg,
  input  logic                 approx_en,
  input  logic signed [AW-1:0] thr_hi,
  input  logic signed [AW-1:0] thr_lo,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [AW-1:0] out_sum,
  output logic [1:0]           out_act
);

  localparam int unsigned BCW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam logic [WIDTH-1:0] APPROX_MASK = {WIDTH{1'b1}} << TRUNC;

  state_e                state_q, state_d;
  logic [BCW-1:0]        bc_q, bc_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic                  approx_q, approx_d;
  logic signed [AW-1:0]  thr_hi_q, thr_hi_d;
  logic signed [AW-1:0]  thr_lo_q, thr_lo_d;
  logic                  out_valid_q, out_valid_d;
  logic signed [AW-1:0]  out_sum_q, out_sum_d;
  logic [1:0]            out_act_q, out_act_d;

  logic                  first_beat, last_beat, accept;
  logic                  approx_eff;
  logic signed [AW-1:0]  thr_hi_eff, thr_lo_eff;
  logic [WIDTH-1:0]      keep_mask, pos_bits, neg_bits;
  logic [CW-1:0]         pc_pos, pc_neg;
  logic signed [AW-1:0]  beat_d, frame_sum;

  // First beat of a frame uses live mode/thresholds; later beats use the latched copy.
  assign first_beat = (state_q == ST_IDLE);
  assign last_beat  = (bc_q == BCW'(FRAMES - 1));
  assign approx_eff = first_beat ? approx_en : approx_q;
  assign thr_hi_eff = first_beat ? thr_hi : thr_hi_q;
  assign thr_lo_eff = first_beat ? thr_lo : thr_lo_q;

  // Bits set in both masks cancel to zero weight.
  assign keep_mask = approx_eff ? APPROX_MASK : {WIDTH{1'b1}};
  assign pos_bits  = in_pos & ~in_neg & keep_mask;
  assign neg_bits  = in_neg & ~in_pos & keep_mask;

  popcount_core #(.WIDTH(WIDTH)) u_pc_pos (.bits_i(pos_bits), .count_o(pc_pos));
  popcount_core #(.WIDTH(WIDTH)) u_pc_neg (.bits_i(neg_bits), .count_o(pc_neg));

  assign beat_d    = $signed(AW'(pc_pos)) - $signed(AW'(pc_neg));
  assign frame_sum = (first_beat ? AW'(0) : acc_q) + beat_d;

  // A result slot frees up in the same cycle it is consumed.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !clear;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else if (accept) begin
      state_d = last_beat ? ST_IDLE : ST_ACCUM;
    end
  end

  // Datapath / output next values
  always_comb begin
    bc_d        = bc_q;
    acc_d       = acc_q;
    approx_d    = approx_q;
    thr_hi_d    = thr_hi_q;
    thr_lo_d    = thr_lo_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_act_d   = out_act_q;

    if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (clear) begin
      bc_d  = '0;
      acc_d = '0;
    end else if (accept) begin
      if (first_beat) begin
        approx_d = approx_en;
        thr_hi_d = thr_hi;
        thr_lo_d = thr_lo;
      end
      if (last_beat) begin
        bc_d        = '0;
        acc_d       = '0;
        out_valid_d = 1'b1;
        out_sum_d   = frame_sum;
        // Upper threshold takes priority when both conditions hold.
        if (frame_sum >= thr_hi_eff) begin
          out_act_d = ACT_POS;
        end else if (frame_sum <= thr_lo_eff) begin
          out_act_d = ACT_NEG;
        end else begin
          out_act_d = ACT_ZERO;
        end
      end else begin
        bc_d  = bc_q + BCW'(1);
        acc_d = frame_sum;
      end
    end
  end

  // Datapath / output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bc_q        <= '0;
      acc_q       <= '0;
      approx_q    <= 1'b0;
      thr_hi_q    <= '0;
      thr_lo_q    <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_act_q   <= ACT_ZERO;
    end else begin
      bc_q        <= bc_d;
      acc_q       <= acc_d;
      approx_q    <= approx_d;
      thr_hi_q    <= thr_hi_d;
      thr_lo_q    <= thr_lo_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_act_q   <= out_act_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_act   = out_act_q;

endmodule

// File: tb/tb_popcount_stream_neuron.sv
// Directed self-checking bench for popcount_stream_neuron (WIDTH=10, FRAMES=4, TRUNC=2).
module tb_popcount_stream_neuron;

  localparam int unsigned WIDTH = 10;
  localparam int unsigned AW    = 7;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 clear;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_pos;
  logic [WIDTH-1:0]     in_neg;
  logic                 approx_en;
  logic signed [AW-1:0] thr_hi;
  logic signed [AW-1:0] thr_lo;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [AW-1:0] out_sum;
  logic [1:0]           out_act;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  popcount_stream_neuron #(.WIDTH(10), .FRAMES(4), .TRUNC(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pos    (in_pos),
    .in_neg    (in_neg),
    .approx_en (approx_en),
    .thr_hi    (thr_hi),
    .thr_lo    (thr_lo),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_act   (out_act)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input int v, input int sum, input int act);
    check({tag, "_valid"}, 32'(out_valid), v);
    check({tag, "_sum"}, 32'(out_sum), sum);
    check({tag, "_act"}, 32'(out_act), act);
  endtask

  // One accepted beat: drive between edges, clock once, sample 1 ns after the edge.
  task automatic beat(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] n,
                      input logic ax, input int hi, input int lo);
    in_pos    = p;
    in_neg    = n;
    approx_en = ax;
    thr_hi    = AW'(hi);
    thr_lo    = AW'(lo);
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
  endtask

  task automatic beats4(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] n,
                        input int hi, input int lo);
    for (int i = 0; i < 4; i++) beat(p, n, 1'b0, hi, lo);
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_pos    = '0;
    in_neg    = '0;
    approx_en = 1'b0;
    thr_hi    = '0;
    thr_lo    = '0;
    out_ready = 1'b1;
    #12;
    check_out("reset", 0, 0, 0);
    check("reset_in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Exact frame: +10 x4 = 40, activation +1, valid one cycle after beat 4
    for (int i = 0; i < 3; i++) beat(10'h3FF, 10'h000, 1'b0, 30, -30);
    check("t1_pre_valid", 32'(out_valid), 0);
    beat(10'h3FF, 10'h000, 1'b0, 30, -30);
    check_out("t1", 1, 40, 1);
    @(posedge clk);
    #1;
    check("t1_drain_valid", 32'(out_valid), 0);

    // Approx frame: bits 1:0 dropped, mid-frame toggle ignored
    beat(10'h3FF, 10'h003, 1'b1, 30, -30);
    for (int i = 0; i < 3; i++) beat(10'h3FF, 10'h003, 1'b0, 30, -30);
    check_out("t2a", 1, 32, 1);
    // Approx on first beat only; later threshold changes must not apply
    beat(10'h3FF, 10'h000, 1'b1, 35, -30);
    for (int i = 0; i < 3; i++) beat(10'h3FF, 10'h000, 1'b0, 0, 0);
    check_out("t2b", 1, 32, 0);
    // Exact on first beat; approx asserted later is ignored
    beat(10'h3FF, 10'h000, 1'b0, 35, -30);
    for (int i = 0; i < 3; i++) beat(10'h3FF, 10'h000, 1'b1, 35, -30);
    check_out("t2c", 1, 40, 1);

    // Overlapping masks cancel; sum 0 with thr_hi=thr_lo=0 -> +1 wins
    beats4(10'h3FF, 10'h3FF, 0, 0);
    check_out("t3a", 1, 0, 1);
    // All -1: -40 at thr_lo boundary -> -1
    beats4(10'h000, 10'h3FF, 30, -40);
    check_out("t3b", 1, -40, 3);
    // Mixed beats: +10, -9, +4, 0 = 5 at thr_hi boundary
    beat(10'h3FF, 10'h000, 1'b0, 5, -5);
    beat(10'h001, 10'h3FF, 1'b0, 5, -5);
    beat(10'h0FF, 10'h00F, 1'b0, 5, -5);
    beat(10'h3FF, 10'h3FF, 1'b0, 5, -5);
    check_out("t3c", 1, 5, 1);
    @(posedge clk);
    #1;

    // Backpressure: result held, input stalled, clear leaves pending result
    out_ready = 1'b0;
    beats4(10'h3FF, 10'h000, 30, -30);
    check_out("t4_done", 1, 40, 1);
    check("t4_in_ready_low", 32'(in_ready), 0);
    in_pos   = 10'h3FF;
    in_neg   = 10'h000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check_out("t4_hold", 1, 40, 1);
    check("t4_in_ready_hold", 32'(in_ready), 0);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check_out("t4_clear_keeps", 1, 40, 1);
    in_pos    = 10'h001;
    thr_hi    = AW'(30);
    thr_lo    = AW'(-30);
    approx_en = 1'b0;
    out_ready = 1'b1;
    #1;
    check("t4_in_ready_release", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("t4_consumed_valid", 32'(out_valid), 0);
    for (int i = 0; i < 3; i++) beat(10'h001, 10'h000, 1'b0, 30, -30);
    check_out("t4_frame2", 1, 4, 0);

    // Clear after 2 beats with a concurrent beat that must be dropped
    beat(10'h3FF, 10'h000, 1'b0, 30, -30);
    beat(10'h3FF, 10'h000, 1'b0, 30, -30);
    clear    = 1'b1;
    in_pos   = 10'h3FF;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    check("t5_after_clear_valid", 32'(out_valid), 0);
    for (int i = 0; i < 3; i++) beat(10'h00F, 10'h000, 1'b0, 30, -30);
    check("t5_pre_valid", 32'(out_valid), 0);
    beat(10'h00F, 10'h000, 1'b0, 30, -30);
    check_out("t5", 1, 16, 0);
    @(posedge clk);
    #1;

    // Reset mid-frame (bc=3) with a stale nonzero out_sum
    out_ready = 1'b0;
    beats4(10'h3FF, 10'h000, 30, -30);
    check_out("t6_setup", 1, 40, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) beat(10'h3FF, 10'h000, 1'b0, 30, -30);
    check_out("t6_midframe", 0, 40, 1);
    rst_n = 1'b0;
    #2;
    check_out("t6_async_rst", 0, 0, 0);
    check("t6_rst_in_ready", 32'(in_ready), 1);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) beat(10'h003, 10'h000, 1'b0, 30, -30);
    check("t6_pre_valid", 32'(out_valid), 0);
    beat(10'h003, 10'h000, 1'b0, 30, -30);
    check_out("t6_post_rst", 1, 8, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
